fila_entrada: RTL and testbench

Input front-end for the 8-entry byte queue (`fila`). It debounces the two raw push-buttons and captures the 8-bit switch value. It then issues single-cycle `enqueue_in`/`dequeue_in` pulses plus `data_in` directly to the queue. It uses the queue's occupancy feedback to refuse enqueue-when-full and dequeue-when-empty, so the queue never overflows or underflows.

---
 rtl/fila_entrada.sv | 170 +++++++++++++++++
 tb/tb_fila_entrada.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fila_entrada.sv
// fila_entrada: input front-end for the 8-entry byte queue.
// It debounces the enqueue/dequeue push-buttons and double-registers the
// switch value. It then issues single-cycle enqueue/dequeue pulses to the
// queue, and uses the queue occupancy to refuse overflow and underflow
// requests.
//
// Ports:
//   clk_10KHz  - system clock, all state on its rising edge
//   reset      - asynchronous active-high reset
//   btn_enq    - raw enqueue push-button (async, active-high)
//   btn_deq    - raw dequeue push-button (async, active-high)
//   sw_data    - raw switch value to enqueue
//   len_in     - queue occupancy 0..DEPTH (from the queue's len_out)
//   data_in    - registered byte for the queue, valid while enqueue_in is high
//   enqueue_in - one-cycle enqueue pulse
//   dequeue_in - one-cycle dequeue pulse
//   full_out   - len_in >= DEPTH (combinational)
//   empty_out  - len_in == 0 (combinational)
//   err_out    - sticky: the last request was refused
module fila_entrada #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              btn_enq,
  input  logic              btn_deq,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [3:0]        len_in,
  output logic [DATA_W-1:0] data_in,
  output logic              enqueue_in,
  output logic              dequeue_in,
  output logic              full_out,
  output logic              empty_out,
  output logic              err_out
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  // The flip happens on the edge where the counter would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DEPTH_L  = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENQ  = 2'd1,
    DEQ  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Button vectors: bit 0 = enqueue, bit 1 = dequeue.
  logic [1:0]        btn_meta_q, btn_meta_d;
  logic [1:0]        btn_sync_q, btn_sync_d;
  logic [DATA_W-1:0] sw_meta_q, sw_meta_d;
  logic [DATA_W-1:0] sw_sync_q, sw_sync_d;
  logic [CW-1:0]     cnt_q [2];
  logic [CW-1:0]     cnt_d [2];
  logic [1:0]        db_q, db_d;
  logic [1:0]        db_prev_q, db_prev_d;
  logic [1:0]        rise_q, rise_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              enq_q, enq_d;
  logic              deq_q, deq_d;
  logic              err_q, err_d;

  // Synchronizers, debouncers and rising-edge detection
  always_comb begin
    btn_meta_d = {btn_deq, btn_enq};
    btn_sync_d = btn_meta_q;
    sw_meta_d  = sw_data;
    sw_sync_d  = sw_meta_q;
    db_prev_d  = db_q;
    rise_d     = db_q & ~db_prev_q;
    db_d       = db_q;
    cnt_d[0]   = cnt_q[0];
    cnt_d[1]   = cnt_q[1];
    for (int i = 0; i < 2; i++) begin
      if (btn_sync_q[i] == db_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = {CW{1'b0}};
        db_d[i]  = ~db_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end
    end
  end

  // Request FSM and registered outputs
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Enqueue wins a same-cycle tie; the dequeue request is dropped silently.
        if (rise_q[0]) begin
          if (len_in < DEPTH_L) begin
            data_d  = sw_sync_q;
            err_d   = 1'b0;
            state_d = ENQ;
          end else begin
            err_d   = 1'b1;
          end
        end else if (rise_q[1]) begin
          if (len_in != 4'd0) begin
            err_d   = 1'b0;
            state_d = DEQ;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ENQ:     state_d = HOLD;
      DEQ:     state_d = HOLD;
      // HOLD lets the queue's updated len_in settle before the next decision.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Pulses are registered so they coincide exactly with the ENQ/DEQ cycle.
    enq_d = (state_d == ENQ);
    deq_d = (state_d == DEQ);
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 2'b00;
      btn_sync_q <= 2'b00;
      sw_meta_q  <= {DATA_W{1'b0}};
      sw_sync_q  <= {DATA_W{1'b0}};
      cnt_q[0]   <= {CW{1'b0}};
      cnt_q[1]   <= {CW{1'b0}};
      db_q       <= 2'b00;
      db_prev_q  <= 2'b00;
      rise_q     <= 2'b00;
      state_q    <= IDLE;
      data_q     <= {DATA_W{1'b0}};
      enq_q      <= 1'b0;
      deq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      rise_q     <= rise_d;
      state_q    <= state_d;
      data_q     <= data_d;
      enq_q      <= enq_d;
      deq_q      <= deq_d;
      err_q      <= err_d;
    end
  end

  assign data_in    = data_q;
  assign enqueue_in = enq_q;
  assign dequeue_in = deq_q;
  assign err_out    = err_q;
  assign full_out   = (len_in >= DEPTH_L);
  assign empty_out  = (len_in == 4'd0);

endmodule

// File: tb/tb_fila_entrada.sv
// Directed self-checking bench for fila_entrada (DEBOUNCE_CYCLES = 4, DEPTH = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fila_entrada;

  logic       clk_10KHz = 1'b0;
  logic       reset;
  logic       btn_enq;
  logic       btn_deq;
  logic [7:0] sw_data;
  logic [3:0] len_in;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic       full_out;
  logic       empty_out;
  logic       err_out;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent scan window.
  int         sc_enq, sc_deq, sc_enq_at, sc_deq_at, sc_bad;
  logic [7:0] sc_data;

  fila_entrada #(
    .DATA_W          (8),
    .DEPTH           (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .btn_enq    (btn_enq),
    .btn_deq    (btn_deq),
    .sw_data    (sw_data),
    .len_in     (len_in),
    .data_in    (data_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .full_out   (full_out),
    .empty_out  (empty_out),
    .err_out    (err_out)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watch n falling edges, counting pulses, their first position and illegal combinations.
  task automatic scan(input int n);
    sc_enq = 0; sc_deq = 0; sc_enq_at = 0; sc_deq_at = 0; sc_bad = 0; sc_data = 8'h00;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_10KHz);
      if (enqueue_in === 1'b1) begin
        if (sc_enq == 0) begin
          sc_enq_at = i;
          sc_data   = data_in;
        end
        sc_enq++;
      end
      if (dequeue_in === 1'b1) begin
        if (sc_deq == 0) sc_deq_at = i;
        sc_deq++;
      end
      if ((enqueue_in === 1'b1 && dequeue_in === 1'b1) ||
          (enqueue_in === 1'b1 && len_in >= 4'd8) ||
          (dequeue_in === 1'b1 && len_in == 4'd0))
        sc_bad++;
    end
  endtask

  initial begin
    reset = 1'b1; btn_enq = 1'b0; btn_deq = 1'b0; sw_data = 8'h00; len_in = 4'd0;

    // Reset state
    repeat (3) @(negedge clk_10KHz);
    chk("rst_data", {24'd0, data_in}, 32'h00);
    chk("rst_enq", {31'd0, enqueue_in}, 32'd0);
    chk("rst_deq", {31'd0, dequeue_in}, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    chk("rst_empty", {31'd0, empty_out}, 32'd1);
    chk("rst_full", {31'd0, full_out}, 32'd0);
    reset = 1'b0;
    scan(4);

    // Clean press held for 20 cycles: one pulse 8 edges later
    sw_data = 8'hA5; len_in = 4'd0; btn_enq = 1'b1;
    scan(20);
    chk("clean_enq_cnt", sc_enq, 1);
    chk("clean_enq_at", sc_enq_at, 8);
    chk("clean_data", {24'd0, sc_data}, 32'hA5);
    chk("clean_deq_cnt", sc_deq, 0);
    chk("clean_err", {31'd0, err_out}, 32'd0);
    chk("clean_bad", sc_bad, 0);
    sw_data = 8'h11;
    btn_enq = 1'b0;
    scan(12);
    chk("release_enq_cnt", sc_enq, 0);
    chk("data_hold", {24'd0, data_in}, 32'hA5);

    // Bounce: 2 high / 2 low for 20 cycles, then low
    sc_bad = 0;
    begin
      int tot = 0;
      for (int i = 0; i < 20; i++) begin
        btn_enq = ((i / 2) % 2 == 0);
        scan(1);
        tot += sc_enq;
      end
      btn_enq = 1'b0;
      scan(12);
      tot += sc_enq;
      chk("bounce_enq_cnt", tot, 0);
    end

    // Overflow guard
    len_in = 4'd8; btn_enq = 1'b1;
    scan(16);
    chk("full_enq_cnt", sc_enq, 0);
    chk("full_err", {31'd0, err_out}, 32'd1);
    chk("full_flag", {31'd0, full_out}, 32'd1);
    btn_enq = 1'b0;
    scan(12);

    // Dequeue with data present clears the error
    len_in = 4'd3; btn_deq = 1'b1;
    scan(16);
    chk("deq_cnt", sc_deq, 1);
    chk("deq_at", sc_deq_at, 8);
    chk("deq_enq_cnt", sc_enq, 0);
    chk("deq_err", {31'd0, err_out}, 32'd0);
    chk("deq_full", {31'd0, full_out}, 32'd0);
    btn_deq = 1'b0;
    scan(12);

    // Underflow guard
    len_in = 4'd0; btn_deq = 1'b1;
    scan(16);
    chk("under_deq_cnt", sc_deq, 0);
    chk("under_err", {31'd0, err_out}, 32'd1);
    chk("under_empty", {31'd0, empty_out}, 32'd1);
    btn_deq = 1'b0;
    scan(12);

    // Simultaneous press: enqueue wins, no error for the dropped dequeue
    len_in = 4'd2; sw_data = 8'h3C; btn_enq = 1'b1; btn_deq = 1'b1;
    scan(16);
    chk("sim_enq_cnt", sc_enq, 1);
    chk("sim_enq_at", sc_enq_at, 8);
    chk("sim_data", {24'd0, sc_data}, 32'h3C);
    chk("sim_deq_cnt", sc_deq, 0);
    chk("sim_err", {31'd0, err_out}, 32'd0);
    chk("sim_empty", {31'd0, empty_out}, 32'd0);
    chk("sim_bad", sc_bad, 0);
    btn_enq = 1'b0; btn_deq = 1'b0;
    scan(12);

    // Async reset during the ENQ cycle, button kept held
    len_in = 4'd0; sw_data = 8'h5A; btn_enq = 1'b1;
    scan(7);
    chk("ar_pre_cnt", sc_enq, 0);
    @(negedge clk_10KHz);
    chk("ar_pulse", {31'd0, enqueue_in}, 32'd1);
    chk("ar_pulse_data", {24'd0, data_in}, 32'h5A);
    #2 reset = 1'b1;
    #1;
    chk("ar_enq_drop", {31'd0, enqueue_in}, 32'd0);
    chk("ar_data_clr", {24'd0, data_in}, 32'h00);
    @(negedge clk_10KHz);
    reset = 1'b0;
    scan(16);
    chk("ar_enq_cnt", sc_enq, 1);
    chk("ar_enq_at", sc_enq_at, 8);
    chk("ar_data", {24'd0, sc_data}, 32'h5A);
    chk("ar_bad", sc_bad, 0);
    btn_enq = 1'b0;
    scan(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
